// File: rtl/esp32_prog_ctrl.sv
// ESP32 auto-programming controller: turns FTDI DTR/RTS into EN/IO0 strapping
// and tracks whether a flash session is in progress.
module esp32_prog_ctrl #(
    parameter int FILTER_CYCLES = 4,
    parameter int RELEASE_BITS  = 24
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       ftdi_ndtr,
    input  logic       ftdi_nrts,
    input  logic       ftdi_txd,
    input  logic       btn_n,
    output logic       wifi_en,
    output logic       wifi_gpio0,
    output logic       prog_active,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        PROG  = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);
    localparam int         TMSB     = RELEASE_BITS - 1;

    // Bit 0 is the first synchronizer flop, bit 1 the one logic may use.
    logic [1:0]              dtr_sync, rts_sync, txd_sync, btn_sync;
    logic                    txd_d;
    logic [1:0]              pair_s, cand, filt;
    logic [7:0]              cnt;
    logic                    filt_upd;
    logic                    txd_fall, timer_clr;
    logic [RELEASE_BITS-1:0] timer, timer_nxt;
    logic                    en_d, io0_d;
    state_t                  state, state_nxt;

    assign pair_s    = {dtr_sync[1], rts_sync[1]};
    assign state_dbg = state;

    // The candidate register delays the pair by one more cycle so a level is
    // only accepted once it has stayed put across the whole count window.
    assign filt_upd  = (pair_s == cand) && (cand != filt) && (cnt == CNT_LAST);
    assign txd_fall  = txd_d & ~txd_sync[1];
    assign timer_clr = filt_upd | txd_fall;

    always_comb begin
        {en_d, io0_d} = 2'b11;
        case (filt)
            2'b10:   {en_d, io0_d} = 2'b01;
            2'b01:   {en_d, io0_d} = 2'b10;
            default: {en_d, io0_d} = 2'b11;
        endcase
    end

    always_comb begin
        timer_nxt = timer;
        if (timer_clr) begin
            timer_nxt = '0;
        end else if (!timer[TMSB]) begin
            timer_nxt = timer + 1'b1;
        end
    end

    // Re-reset from the host (pair 10) wins over the release timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (filt == 2'b10) state_nxt = ARMED;
            end
            ARMED: begin
                if (filt == 2'b01) state_nxt = PROG;
                else if (filt == 2'b11 || filt == 2'b00) state_nxt = IDLE;
            end
            PROG: begin
                if (filt == 2'b10) state_nxt = ARMED;
                else if (timer_nxt[TMSB]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            dtr_sync    <= 2'b11;
            rts_sync    <= 2'b11;
            txd_sync    <= 2'b11;
            btn_sync    <= 2'b11;
            txd_d       <= 1'b1;
            cand        <= 2'b11;
            filt        <= 2'b11;
            cnt         <= '0;
            timer       <= '0;
            state       <= IDLE;
            prog_active <= 1'b0;
            wifi_en     <= 1'b1;
            wifi_gpio0  <= 1'b1;
        end else begin
            dtr_sync <= {dtr_sync[0], ftdi_ndtr};
            rts_sync <= {rts_sync[0], ftdi_nrts};
            txd_sync <= {txd_sync[0], ftdi_txd};
            btn_sync <= {btn_sync[0], btn_n};
            txd_d    <= txd_sync[1];
            cand     <= pair_s;
            if (pair_s != cand || cand == filt || filt_upd) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (filt_upd) begin
                filt <= cand;
            end
            // Outside PROG the timer sits at zero, so entry always starts fresh.
            timer       <= (state == PROG) ? timer_nxt : '0;
            state       <= state_nxt;
            prog_active <= (state_nxt == PROG);
            wifi_en     <= en_d;
            wifi_gpio0  <= io0_d & btn_sync[1];
        end
    end

endmodule

// File: doc/esp32_prog_ctrl.md
ESP32_PROG_CTRL -- requirements
Module: esp32_prog_ctrl

Interface
REQ-001 The block SHALL have parameter FILTER_CYCLES, default 4: the number of consecutive cycles a synchronized DTR/RTS level must hold before it is accepted (range 1..255).
REQ-002 The block SHALL have parameter RELEASE_BITS, default 24: the width of the programming-release timer; the timeout is 2^(RELEASE_BITS-1) cycles (about 0.34 s at 25 MHz).
REQ-003 The block SHALL have port clk_25mhz, input, 1 bit: the single clock for the whole block.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port ftdi_ndtr, input, 1 bit: FTDI DTR, asynchronous to clk_25mhz.
REQ-006 The block SHALL have port ftdi_nrts, input, 1 bit: FTDI RTS, asynchronous to clk_25mhz.
REQ-007 The block SHALL have port ftdi_txd, input, 1 bit: host-to-ESP32 serial line, asynchronous, idle high.
REQ-008 The block SHALL have port btn_n, input, 1 bit: active-low manual boot override, asynchronous.
REQ-009 The block SHALL have port wifi_en, output, 1 bit: ESP32 EN pin, registered.
REQ-010 The block SHALL have port wifi_gpio0, output, 1 bit: ESP32 IO0 pin, registered.
REQ-011 The block SHALL have port prog_active, output, 1 bit: high while an ESP32 flash session is in progress.
REQ-012 The block SHALL have port state_dbg, output, 2 bits: current FSM state encoding, for the LEDs.

Function
REQ-013 The block SHALL pass ftdi_ndtr, ftdi_nrts, ftdi_txd and btn_n each through its own 2-flop synchronizer before any other logic uses them.
REQ-014 The block SHALL keep a filtered pair {dtr_f, rts_f} that updates to a new synchronized pair only after that pair has been identical for FILTER_CYCLES consecutive cycles; any change in the pair SHALL restart the count.
REQ-015 The block SHALL decode {dtr_f, rts_f} to {en_d, io0_d} as follows: 11 -> 11, 00 -> 11, 10 -> 01, 01 -> 10.
REQ-016 The block SHALL drive wifi_en as a register loaded with en_d every cycle.
REQ-017 The block SHALL drive wifi_gpio0 as a register loaded with (io0_d AND synchronized btn_n) every cycle.
REQ-018 The latency from the first clock edge that samples a new stable DTR/RTS level to the change on wifi_en/wifi_gpio0 SHALL be exactly FILTER_CYCLES+3 cycles.
REQ-019 The block SHALL implement an FSM with states IDLE (state_dbg=00), ARMED (01) and PROG (10); encoding 11 SHALL be unreachable and SHALL return to IDLE.
REQ-020 In IDLE, the FSM SHALL go to ARMED when the filtered pair becomes 10 (EN low), and SHALL otherwise stay in IDLE.
REQ-021 In ARMED, the FSM SHALL go to PROG when the filtered pair becomes 01, go to IDLE when it becomes 11 or 00, and stay in ARMED while it is 10.
REQ-022 On entering PROG, the block SHALL clear the release timer; prog_active SHALL be high exactly while the state is PROG, registered together with the state.
REQ-023 In PROG, the release timer SHALL increment each cycle and SHALL clear on any filtered-pair change or on a falling edge of the synchronized ftdi_txd; a clear SHALL take priority over the increment in the same cycle.
REQ-024 In PROG, the FSM SHALL go to IDLE on the cycle the timer MSB is first 1, and the timer SHALL NOT count past that point.
REQ-025 In PROG, a filtered pair of 10 SHALL go to ARMED (the host is re-resetting), and this transition SHALL take priority over the timeout.
REQ-026 The button override SHALL affect only wifi_gpio0; it SHALL NOT change FSM state or the timer.

Reset
REQ-027 While rst_n is sampled low, the block SHALL force: all synchronizer flops and {dtr_f, rts_f} to 1; the filter count and release timer to 0; state IDLE; wifi_en=1; wifi_gpio0=1; prog_active=0; state_dbg=00.
REQ-028 A reset asserted in ARMED or PROG SHALL abort the session on the next edge, with no partial timer retained.
REQ-029 After rst_n is released with the pins idle high, the outputs SHALL stay at 1/1 with no glitch.

Verification (FILTER_CYCLES=4, RELEASE_BITS=8 in simulation)
REQ-030 Bench scenario, esptool entry: pins 11 -> 10 held 20 cycles -> 01 -> wifi_en goes 0 then 1 and wifi_gpio0 goes 1 then 0, each change exactly 7 cycles after sampling; state goes IDLE -> ARMED -> PROG; prog_active=1.
REQ-031 Bench scenario, glitch rejection: ndtr pulsed low for 3 cycles from 11 -> no change on any output, and the state stays IDLE.
REQ-032 Bench scenario, timeout: in PROG with pins 11 and txd idle -> prog_active falls exactly 128 cycles after the last timer clear.
REQ-033 Bench scenario, txd activity: in PROG, txd falling edges every 100 cycles for 1000 cycles -> prog_active stays 1, and falls 128 cycles after the last edge.
REQ-034 Bench scenario, button override: btn_n held low with pins 11 -> wifi_gpio0=0 after 3 cycles, wifi_en=1, state stays IDLE; on release, wifi_gpio0=1.
REQ-035 Bench scenario, reset mid-session: rst_n pulled low for 1 cycle while in PROG -> next cycle state IDLE, prog_active=0, wifi_en=1, wifi_gpio0=1.
